mass_fork: RTL and testbench

MASS_FORK -- requirements
Module: mass_fork

---
 rtl/mass_fork_pkg.sv | 15 +
 rtl/mass_fork_if.sv | 28 ++
 rtl/mass_fork_clocked_one_shot.sv | 23 ++
 rtl/mass_fork.sv | 130 +++++++++++++
 tb/tb_mass_fork.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mass_fork_pkg.sv
// mass_fork_pkg: shared state encoding and default sizing for the mass_fork
// fork/join round controller.
package mass_fork_pkg;

  localparam int unsigned NUM_LANES_DEF      = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT     = 2'd2,
    S_COMPLETE = 2'd3
  } state_t;

endpackage

// File: rtl/mass_fork_if.sv
// mass_fork_if: request/lane bundle between a round requester (master) and
// the mass_fork controller (slave).
interface mass_fork_if
  import mass_fork_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_DEF
);

  logic                 go;
  logic [NUM_LANES-1:0] lane_mask;
  logic [NUM_LANES-1:0] lane_done;
  logic [NUM_LANES-1:0] start;
  logic                 busy;
  logic [NUM_LANES-1:0] pending;
  logic                 done;
  logic                 timeout;

  modport master (
    output go, lane_mask, lane_done,
    input  start, busy, pending, done, timeout
  );

  modport slave (
    input  go, lane_mask, lane_done,
    output start, busy, pending, done, timeout
  );

endinterface

// File: rtl/mass_fork_clocked_one_shot.sv
// ClockedOneShot: rising-edge detector on a synchronous level. The history
// bit resets to 1 so a level held high across reset release is not seen as
// an edge; the input has to be sampled low once before it can fire.
module ClockedOneShot
  import mass_fork_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // remember the level sampled at the previous edge
  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/mass_fork.sv
// mass_fork: starts a masked set of worker lanes with a one-cycle pulse and
// waits for every started lane to report done.
// Optional watchdog on the WAIT state: define MASS_FORK_TIMEOUT_EN.
//
//  state      | meaning
//  S_IDLE     | waiting for a go rising edge
//  S_ISSUE    | start pulse to the latched lanes
//  S_WAIT     | collecting lane_done until pending is empty
//  S_COMPLETE | one-cycle done pulse, then back to idle
module mass_fork
  import mass_fork_pkg::*;
#(
  parameter int unsigned NUM_LANES      = NUM_LANES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        CLOCK,
  input  logic        reset,
  mass_fork_if.slave  bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_LANES-1:0] r_pending;
  logic [NUM_LANES-1:0] w_pend_cleared;
  logic                 w_go_edge;
  logic                 w_timeout_hit;
  logic [NUM_LANES-1:0] w_start;
  logic                 w_busy;
  logic                 w_done;

  ClockedOneShot u_go_edge (
    .i_clk   (CLOCK),
    .i_rst   (reset),
    .i_level (bus.go),
    .o_pulse (w_go_edge)
  );

  // lanes outside the latched mask are already 0 in pending, so their done is moot
  assign w_pend_cleared = r_pending & ~bus.lane_done;

`ifdef MASS_FORK_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  // down-counter over WAIT cycles; terminal count 0 marks the last allowed cycle
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  assign w_timeout_hit = (r_state == S_WAIT) && (r_wait_cnt == '0);

  // timeout pulse; completion on the same edge wins over the watchdog
  always_ff @(posedge CLOCK) begin
    if (reset) r_timeout <= 1'b0;
    else       r_timeout <= w_timeout_hit && (w_pend_cleared != '0);
  end

  assign bus.timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign bus.timeout   = 1'b0;
`endif

  // state register
  always_ff @(posedge CLOCK) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // latch the mask on an accepted go edge, then retire lanes as they report
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      case (r_state)
        S_IDLE:           if (w_go_edge) r_pending <= bus.lane_mask;
        S_ISSUE, S_WAIT:  r_pending <= w_pend_cleared;
        default:          r_pending <= r_pending;
      endcase
    end
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_go_edge) w_state_nxt = S_ISSUE;
      S_ISSUE:    w_state_nxt = (w_pend_cleared == '0) ? S_COMPLETE : S_WAIT;
      S_WAIT: begin
        if (w_pend_cleared == '0) w_state_nxt = S_COMPLETE;
        else if (w_timeout_hit)   w_state_nxt = S_IDLE;
      end
      S_COMPLETE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from the current state
  always_comb begin
    w_start = '0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_ISSUE: begin
        w_start = r_pending;
        w_busy  = 1'b1;
      end
      S_WAIT:     w_busy = 1'b1;
      S_COMPLETE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.start   = w_start;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.pending = r_pending;

endmodule

// File: tb/tb_mass_fork.sv
// tb_mass_fork: directed vector table for mass_fork plus hand sequences for
// reset-mid-round and (when MASS_FORK_TIMEOUT_EN is defined) the watchdog.
module tb_mass_fork;

  localparam int NL = 4;
`ifdef MASS_FORK_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mass_fork_if #(.NUM_LANES(NL)) bus ();

  mass_fork #(.NUM_LANES(NL), .TIMEOUT_CYCLES(TB_TO)) dut (
    .CLOCK (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       go;
    logic [3:0] mask;
    logic [3:0] ld;
    logic [3:0] st;
    logic       bz;
    logic [3:0] pd;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic go, input logic [3:0] mask, input logic [3:0] ld,
                     input logic [3:0] st, input logic bz, input logic [3:0] pd,
                     input logic dn);
    vec_t v;
    v.go = go; v.mask = mask; v.ld = ld; v.st = st; v.bz = bz; v.pd = pd; v.dn = dn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic bz,
                         input logic [3:0] pd, input logic dn, input logic to);
    chk({tag, ".start"},   32'(bus.start),   32'(st));
    chk({tag, ".busy"},    32'(bus.busy),    32'(bz));
    chk({tag, ".pending"}, 32'(bus.pending), 32'(pd));
    chk({tag, ".done"},    32'(bus.done),    32'(dn));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //    go mask     done     start    busy pending  done
    // four lanes, singles in order 2,0,3,1
    add(1, 4'b1111, 4'b0000, 4'b1111, 1, 4'b1111, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 1, 4'b1111, 0);
    add(1, 4'b1111, 4'b0100, 4'b0000, 1, 4'b1011, 0);
    add(1, 4'b1111, 4'b0001, 4'b0000, 1, 4'b1010, 0);
    add(1, 4'b1111, 4'b1000, 4'b0000, 1, 4'b0010, 0);
    add(1, 4'b1111, 4'b0010, 4'b0000, 1, 4'b0000, 1);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // unmasked done ignored
    add(1, 4'b0101, 4'b0000, 4'b0101, 1, 4'b0101, 0);
    add(0, 4'b0101, 4'b1010, 4'b0000, 1, 4'b0101, 0);
    add(0, 4'b0101, 4'b0101, 4'b0000, 1, 4'b0000, 1);
    add(0, 4'b0101, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // empty mask: ISSUE then COMPLETE
    add(1, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // held done level, second go edge during WAIT
    add(1, 4'b0011, 4'b0000, 4'b0011, 1, 4'b0011, 0);
    add(0, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0010, 0);
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0010, 0);
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0010, 0);
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 4'b0010, 0);
    add(1, 4'b0011, 4'b0011, 4'b0000, 1, 4'b0000, 1);
    for (int i = 0; i < 5; i++)
      add(1, 4'b0011, 4'b0001, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0011, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    // done sampled in ISSUE completes directly; mask change after the edge ignored
    add(1, 4'b0101, 4'b0000, 4'b0101, 1, 4'b0101, 0);
    add(0, 4'b1111, 4'b0101, 4'b0000, 1, 4'b0000, 1);
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    rst = 1'b1;
    bus.go = 1'b0;
    bus.lane_mask = '0;
    bus.lane_done = '0;
    step();
    step();
    chk_all("reset", 4'b0000, 0, 4'b0000, 0, 0);
    rst = 1'b0;
    step();
    chk_all("post_reset", 4'b0000, 0, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      bus.go        = vecs[i].go;
      bus.lane_mask = vecs[i].mask;
      bus.lane_done = vecs[i].ld;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].st, vecs[i].bz, vecs[i].pd, vecs[i].dn, 1'b0);
    end

    // reset during WAIT, go held high through release
    bus.go = 1'b1; bus.lane_mask = 4'b0110; bus.lane_done = '0;
    step();
    chk_all("rst_issue", 4'b0110, 1, 4'b0110, 0, 0);
    step();
    chk_all("rst_wait", 4'b0000, 1, 4'b0110, 0, 0);
    rst = 1'b1;
    step();
    chk_all("rst_abort", 4'b0000, 0, 4'b0000, 0, 0);
    step();
    chk_all("rst_hold", 4'b0000, 0, 4'b0000, 0, 0);
    rst = 1'b0;
    step();
    chk_all("rst_rel0", 4'b0000, 0, 4'b0000, 0, 0);
    step();
    chk_all("rst_rel1", 4'b0000, 0, 4'b0000, 0, 0);
    bus.go = 1'b0;
    step();
    bus.go = 1'b1;
    step();
    chk_all("rst_reissue", 4'b0110, 1, 4'b0110, 0, 0);
    bus.go = 1'b0; bus.lane_done = 4'b0110;
    step();
    chk_all("rst_complete", 4'b0000, 1, 4'b0000, 1, 0);
    bus.lane_done = '0;
    step();
    chk_all("rst_idle", 4'b0000, 0, 4'b0000, 0, 0);

`ifdef MASS_FORK_TIMEOUT_EN
    // lane 3 never reports: timeout after 8 WAIT cycles, pending held
    bus.go = 1'b1; bus.lane_mask = 4'b1111; bus.lane_done = '0;
    step();
    chk_all("to_issue", 4'b1111, 1, 4'b1111, 0, 0);
    bus.go = 1'b0; bus.lane_done = 4'b0111;
    step();
    chk_all("to_wait1", 4'b0000, 1, 4'b1000, 0, 0);
    bus.lane_done = '0;
    for (int i = 2; i <= 8; i++) begin
      step();
      chk_all($sformatf("to_wait%0d", i), 4'b0000, 1, 4'b1000, 0, 0);
    end
    step();
    chk_all("to_pulse", 4'b0000, 0, 4'b1000, 0, 1);
    step();
    chk_all("to_after", 4'b0000, 0, 4'b1000, 0, 0);
    step();
    chk_all("to_after2", 4'b0000, 0, 4'b1000, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
